result_unloader: RTL and testbench

Output-direction counterpart of the ODE solver chip's CPU loader. After the solver finishes, it reads 64-bit result words from the shared RAM and streams them to the CPU over the 32-bit CPU bus as 32-bit packets: a header, then low/high halves of each word. The CPU paces the transfer with `INT` acknowledge pulses. The block sits beside the I/O loader and shares the RAM's second read port and the `CPU_Bus` tristate.

---
 rtl/result_unloader.sv | 209 ++++++++++++++++++++
 tb/tb_result_unloader.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/result_unloader.sv
`default_nettype none
// ============================================================================
//  Module      : result_unloader
//  Description : Streams 64-bit result words from the shared RAM to the CPU
//                as 32-bit packets. The packet order is a header carrying the
//                word count, then the low half and high half of each word.
//                Each packet is held on the bus until the CPU acknowledges it
//                with an INT rising edge.
//  Ports       : CLK, RST (async, active-low)
//                Start, Base_Address, Word_Count  - unload request from solver
//                INT                              - CPU packet acknowledge
//                RAM_RD_Address / RAM_RD_Data     - RAM read port (1-cycle latency)
//                CPU_Bus_Out, CPU_Bus_OE, Data_Valid - CPU bus packet driver
//                Busy, Done_Unloading             - status
//  Options     : UNLOADER_CHECKSUM_EN - append a final packet that is the XOR of
//                all packets sent, acknowledged like any other packet
//  Revision    : 1.0 - initial release
// ============================================================================
module result_unloader #(
    parameter int RAM_ADDRESS_WIDTH = 13,
    parameter int DATA_WIDTH        = 64   // two 32-bit packets per word; must be 64
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         Start,
    input  logic [RAM_ADDRESS_WIDTH-1:0] Base_Address,
    input  logic [RAM_ADDRESS_WIDTH-1:0] Word_Count,
    input  logic                         INT,
    output logic [RAM_ADDRESS_WIDTH-1:0] RAM_RD_Address,
    input  logic [DATA_WIDTH-1:0]        RAM_RD_Data,
    output logic [31:0]                  CPU_Bus_Out,
    output logic                         CPU_Bus_OE,
    output logic                         Data_Valid,
    output logic                         Busy,
    output logic                         Done_Unloading
);

`ifdef UNLOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HEADER  = 3'd1,
        FETCH   = 3'd2,
        LATCH   = 3'd3,
        SEND_LO = 3'd4,
        SEND_HI = 3'd5,
        CHECK   = 3'd6,
        DONE    = 3'd7
    } state_t;
    localparam state_t c_END_STATE = CHECK;
`else
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HEADER  = 3'd1,
        FETCH   = 3'd2,
        LATCH   = 3'd3,
        SEND_LO = 3'd4,
        SEND_HI = 3'd5,
        DONE    = 3'd7
    } state_t;
    localparam state_t c_END_STATE = DONE;
`endif

    state_t                         r_state, w_state_next;
    logic [RAM_ADDRESS_WIDTH-1:0]   r_base,  w_base_next;
    logic [RAM_ADDRESS_WIDTH-1:0]   r_count, w_count_next;
    logic [RAM_ADDRESS_WIDTH-1:0]   r_index, w_index_next;
    logic [DATA_WIDTH-1:0]          r_hold,  w_hold_next;
    logic [RAM_ADDRESS_WIDTH-1:0]   r_addr,  w_addr_next;
    logic [31:0]                    r_bus,   w_bus_next;
    logic                           r_valid, w_valid_next;
    logic                           r_busy,  w_busy_next;
    logic                           r_done,  w_done_next;
    logic                           r_int_prev;
    logic                           w_ack;
`ifdef UNLOADER_CHECKSUM_EN
    logic [31:0]                    r_xsum,  w_xsum_next;
`endif

    // A level held high counts as a single acknowledge.
    assign w_ack = INT & ~r_int_prev;

    always_comb begin
        w_state_next = r_state;
        w_base_next  = r_base;
        w_count_next = r_count;
        w_index_next = r_index;
        w_hold_next  = r_hold;
        w_addr_next  = r_addr;
        w_bus_next   = r_bus;
`ifdef UNLOADER_CHECKSUM_EN
        w_xsum_next  = r_xsum;
`endif

        case (r_state)
            IDLE: begin
                if (Start) begin
                    w_base_next  = Base_Address;
                    w_count_next = Word_Count;
                    w_index_next = '0;
                    w_state_next = HEADER;
`ifdef UNLOADER_CHECKSUM_EN
                    w_xsum_next  = '0;
`endif
                end
            end
            HEADER: begin
                if (w_ack) begin
`ifdef UNLOADER_CHECKSUM_EN
                    w_xsum_next = r_xsum ^ r_bus;
`endif
                    w_state_next = (r_count == '0) ? c_END_STATE : FETCH;
                end
            end
            FETCH:   w_state_next = LATCH;
            LATCH: begin
                w_hold_next  = RAM_RD_Data;
                w_state_next = SEND_LO;
            end
            SEND_LO: begin
                if (w_ack) begin
`ifdef UNLOADER_CHECKSUM_EN
                    w_xsum_next = r_xsum ^ r_bus;
`endif
                    w_state_next = SEND_HI;
                end
            end
            SEND_HI: begin
                if (w_ack) begin
`ifdef UNLOADER_CHECKSUM_EN
                    w_xsum_next = r_xsum ^ r_bus;
`endif
                    w_index_next = r_index + 1'b1;
                    w_state_next = (w_index_next == r_count) ? c_END_STATE : FETCH;
                end
            end
`ifdef UNLOADER_CHECKSUM_EN
            CHECK: begin
                if (w_ack) w_state_next = DONE;
            end
`endif
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase

        // Outputs are registered, so they are decoded from the state being
        // entered; this makes each packet appear on the same edge as its state.
        case (w_state_next)
            HEADER:  w_bus_next  = 32'(w_count_next);
            FETCH:   w_addr_next = w_base_next + w_index_next;   // wraps modulo 2^AW
            SEND_LO: w_bus_next  = w_hold_next[31:0];
            SEND_HI: w_bus_next  = w_hold_next[63:32];
`ifdef UNLOADER_CHECKSUM_EN
            CHECK:   w_bus_next  = w_xsum_next;   // already includes the last packet
`endif
            default: ;
        endcase

        w_valid_next = (w_state_next == HEADER)  || (w_state_next == SEND_LO) ||
`ifdef UNLOADER_CHECKSUM_EN
                       (w_state_next == CHECK)   ||
`endif
                       (w_state_next == SEND_HI);
        w_busy_next  = (w_state_next != IDLE);
        w_done_next  = (w_state_next == DONE);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state    <= IDLE;
            r_base     <= '0;
            r_count    <= '0;
            r_index    <= '0;
            r_hold     <= '0;
            r_addr     <= '0;
            r_bus      <= '0;
            r_valid    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_int_prev <= 1'b0;
`ifdef UNLOADER_CHECKSUM_EN
            r_xsum     <= '0;
`endif
        end else begin
            r_state    <= w_state_next;
            r_base     <= w_base_next;
            r_count    <= w_count_next;
            r_index    <= w_index_next;
            r_hold     <= w_hold_next;
            r_addr     <= w_addr_next;
            r_bus      <= w_bus_next;
            r_valid    <= w_valid_next;
            r_busy     <= w_busy_next;
            r_done     <= w_done_next;
            r_int_prev <= INT;
`ifdef UNLOADER_CHECKSUM_EN
            r_xsum     <= w_xsum_next;
`endif
        end
    end

    assign RAM_RD_Address = r_addr;
    assign CPU_Bus_Out    = r_bus;
    assign CPU_Bus_OE     = r_valid;   // one register drives both so they never differ
    assign Data_Valid     = r_valid;
    assign Busy           = r_busy;
    assign Done_Unloading = r_done;

endmodule
`default_nettype wire

// File: tb/tb_result_unloader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_result_unloader
//  Description : Scoreboard bench for result_unloader. A CPU-side driver
//                acknowledges packets; the expected packet list for each
//                unload is built from the RAM contents and pushed into a
//                queue, and a monitor pops and compares each accepted packet.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_result_unloader;
    localparam int AW    = 13;
    localparam int DW    = 64;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_address = '0;
    logic [AW-1:0] word_count = '0;
    logic          int_ack = 1'b0;
    logic [AW-1:0] ram_rd_address;
    logic [DW-1:0] ram_rd_data = '0;
    logic [31:0]   cpu_bus_out;
    logic          cpu_bus_oe;
    logic          data_valid;
    logic          busy;
    logic          done_unloading;

    logic [63:0]   ram [DEPTH];
    logic [31:0]   exp_q[$];
    int            n_tests = 0;
    int            n_fail  = 0;
    int            exp_done = 0;
    int            done_seen = 0;

    result_unloader #(.RAM_ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .CLK            (clk),
        .RST            (rst_n),
        .Start          (start),
        .Base_Address   (base_address),
        .Word_Count     (word_count),
        .INT            (int_ack),
        .RAM_RD_Address (ram_rd_address),
        .RAM_RD_Data    (ram_rd_data),
        .CPU_Bus_Out    (cpu_bus_out),
        .CPU_Bus_OE     (cpu_bus_oe),
        .Data_Valid     (data_valid),
        .Busy           (busy),
        .Done_Unloading (done_unloading)
    );

    always #5 clk = ~clk;

    // Synchronous-read RAM: data one cycle after the address.
    always @(posedge clk) ram_rd_data <= ram[ram_rd_address];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    // Reference model: the packet list for one unload.
    task automatic model_push(input int base, input int count);
        logic [31:0] x;
        logic [63:0] w;
        x = 32'(count);
        exp_q.push_back(32'(count));
        for (int i = 0; i < count; i++) begin
            w = ram[(base + i) % DEPTH];
            exp_q.push_back(w[31:0]);
            exp_q.push_back(w[63:32]);
            x = x ^ w[31:0] ^ w[63:32];
        end
`ifdef UNLOADER_CHECKSUM_EN
        exp_q.push_back(x);
`endif
    endtask

    function automatic int n_packets(input int count);
`ifdef UNLOADER_CHECKSUM_EN
        return 2 + 2 * count;
`else
        return 1 + 2 * count;
`endif
    endfunction

    // Monitor: a packet is taken when INT rises while Data_Valid is high.
    initial begin
        logic        int_prev_s;
        logic        done_prev;
        logic [31:0] e;
        int_prev_s = 1'b0;
        done_prev  = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (data_valid && int_ack && !int_prev_s) begin
                    n_tests++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL extra_packet: got %h required no packet", cpu_bus_out);
                    end else begin
                        e = exp_q.pop_front();
                        if (cpu_bus_out !== e || cpu_bus_oe !== 1'b1) begin
                            n_fail++;
                            $display("FAIL packet: got %h oe=%b required %h oe=1", cpu_bus_out, cpu_bus_oe, e);
                        end
                    end
                end
                if (done_prev) begin
                    n_tests++;
                    if (busy !== 1'b0 || done_unloading !== 1'b0) begin
                        n_fail++;
                        $display("FAIL after_done: got busy=%b done=%b required 0 0", busy, done_unloading);
                    end
                end
                done_prev = 1'b0;
                if (done_unloading) begin
                    done_seen++;
                    done_prev = 1'b1;
                    n_tests++;
                    if (exp_q.size() != 0) begin
                        n_fail++;
                        $display("FAIL early_done: got %0d packets pending required 0", exp_q.size());
                    end
                end
            end
            int_prev_s = int_ack;
        end
    end

    task automatic wait_dv(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (data_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL dv_timeout: got Data_Valid=0 required 1");
        end
    endtask

    task automatic ack(input int hold);
        repeat ($urandom_range(0, 2)) @(posedge clk);
        @(posedge clk); #1 int_ack = 1'b1;
        repeat (hold) @(posedge clk);
        #1 int_ack = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic pulse_start(input int base, input int count);
        @(posedge clk); #1;
        start = 1'b1;
        base_address = AW'(base);
        word_count = AW'(count);
        @(posedge clk); #1;
        start = 1'b0;
        base_address = AW'($urandom);
        word_count = AW'($urandom);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL idle_timeout: got Busy=1 required 0");
        end
    endtask

    // One full unload. force_hold>0 fixes the INT width on the first data
    // packet; restart_at>=0 pulses a spurious Start before that packet.
    task automatic run_transfer(input int base, input int count, input int force_hold, input int restart_at);
        bit ok;
        int n;
        n = n_packets(count);
        model_push(base, count);
        exp_done++;
        pulse_start(base, count);
        n_tests++;
        if (data_valid !== 1'b1 || cpu_bus_out !== 32'(count) || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL header_latency: got dv=%b bus=%h busy=%b required 1 %h 1",
                     data_valid, cpu_bus_out, busy, 32'(count));
        end
        for (int k = 0; k < n; k++) begin
            if (k == restart_at) pulse_start(($urandom % DEPTH), 3);
            wait_dv(ok);
            if (!ok) break;
            ack((k == 1 && force_hold > 0) ? force_hold : $urandom_range(1, 3));
        end
        wait_idle();
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL leftover: got %0d pending packets required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        bit ok;
        logic [AW-1:0] a0;
        for (int i = 0; i < DEPTH; i++) ram[i] = {$urandom, $urandom};

        // Reset state
        #3;
        n_tests++;
        if (cpu_bus_oe !== 0 || data_valid !== 0 || busy !== 0 || done_unloading !== 0 ||
            cpu_bus_out !== 0 || ram_rd_address !== 0) begin
            n_fail++;
            $display("FAIL reset_state: got oe=%b dv=%b busy=%b done=%b bus=%h addr=%h required all 0",
                     cpu_bus_oe, data_valid, busy, done_unloading, cpu_bus_out, ram_rd_address);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed example transfer
        ram[16'h10] = 64'h1111_2222_3333_4444;
        ram[16'h11] = 64'h5555_6666_7777_8888;
        run_transfer(32'h10, 2, 0, -1);

        // Count 0: header only, RAM address untouched
        a0 = ram_rd_address;
        run_transfer(32'h123, 0, 0, -1);
        n_tests++;
        if (ram_rd_address !== a0) begin
            n_fail++;
            $display("FAIL count0_addr: got %h required %h", ram_rd_address, a0);
        end

        // Address wrap
        run_transfer(32'h1FFF, 2, 0, -1);

        // INT held 5 cycles on SEND_LO, spurious Start mid-transfer
        run_transfer(32'h40, 2, 5, 3);

`ifdef UNLOADER_CHECKSUM_EN
        ram[16'h200] = 64'h0000_00F0_0000_000F;
        run_transfer(32'h200, 1, 0, -1);
`endif

        // Random transfers
        for (int t = 0; t < 12; t++)
            run_transfer($urandom % DEPTH, $urandom_range(0, 6), $urandom_range(0, 5), -1);

        // Reset in the middle of SEND_LO: aborts silently
        model_push(32'h300, 3);
        pulse_start(32'h300, 3);
        wait_dv(ok);
        ack(1);
        wait_dv(ok);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (cpu_bus_oe !== 0 || data_valid !== 0 || busy !== 0) begin
            n_fail++;
            $display("FAIL reset_abort: got oe=%b dv=%b busy=%b required 0 0 0", cpu_bus_oe, data_valid, busy);
        end
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        n_tests++;
        if (busy !== 0 || data_valid !== 0 || done_unloading !== 0) begin
            n_fail++;
            $display("FAIL post_reset_idle: got busy=%b dv=%b done=%b required 0 0 0", busy, data_valid, done_unloading);
        end

        // One more normal transfer after the abort
        run_transfer($urandom % DEPTH, 2, 0, -1);

        repeat (3) @(negedge clk);
        n_tests++;
        if (done_seen != exp_done) begin
            n_fail++;
            $display("FAIL done_count: got %0d required %0d", done_seen, exp_done);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
